// File: rtl/npc_pkg.sv
// Shared opcode constants, FSM/immediate/ALU enums and decode helpers for the npc_mc core.
package npc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U, IMM_J} imm_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_PASSB} alu_op_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_t t);
    case (t)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic idx_ok(input logic [4:0] f, input int n);
    return int'(f) < n;
  endfunction

endpackage

// File: rtl/npc_regfile.sv
// GPR file: two combinational read ports, a debug read port, one synchronous write port.
module npc_regfile #(
  parameter  int NR_REGS = 32,
  localparam int AW      = $clog2(NR_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  output logic [31:0]   rd1,
  input  logic [AW-1:0] ra2,
  output logic [31:0]   rd2,
  input  logic [4:0]    dbg_ra,
  output logic [31:0]   dbg_rd,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd
);

  logic [31:0] regs [NR_REGS];

  assign rd1    = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2    = (ra2 == '0) ? '0 : regs[ra2];
  assign dbg_rd = (dbg_ra == '0 || int'(dbg_ra) >= NR_REGS) ? '0 : regs[dbg_ra[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NR_REGS; i++) regs[AW'(i)] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/npc_mc.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/WB with halt/trap.
// NPC_MC_COMMIT_TRACE_EN adds the commit_valid/commit_pc/commit_inst trace outputs.
module npc_mc
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32,
  parameter int          REG_AW   = $clog2(NR_REGS)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifetch_req,
  output logic [31:0] ifetch_addr,
  input  logic        ifetch_valid,
  input  logic [31:0] ifetch_inst,
  output logic [31:0] pc,
  output logic        halt,
  output logic        trap,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
`ifdef NPC_MC_COMMIT_TRACE_EN
  ,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst
`endif
);

  state_t      state, state_nx;
  logic [31:0] pc_q, inst_q, op_a, op_b, res_q, npc_q;
  logic        trap_q, trap_set, rf_we;
  logic [31:0] rs1_val, rs2_val, imm, alu_out;

  logic [6:0] opcode, f7;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic [2:0] f3;
  assign opcode = inst_q[6:0];
  assign rd_f   = inst_q[11:7];
  assign f3     = inst_q[14:12];
  assign rs1_f  = inst_q[19:15];
  assign rs2_f  = inst_q[24:20];
  assign f7     = inst_q[31:25];

  imm_t    imm_sel;
  alu_op_t alu_op;
  logic    illegal, use_pc, use_imm, is_jump, is_ebreak, wen;

  // Decode is derived from inst_q, which stays stable from DECODE through WB.
  always_comb begin
    illegal   = 1'b1;
    imm_sel   = IMM_I;
    alu_op    = ALU_ADD;
    use_pc    = 1'b0;
    use_imm   = 1'b1;
    is_jump   = 1'b0;
    is_ebreak = 1'b0;
    wen       = 1'b0;
    case (opcode)
      OP_IMM: if (f3 == 3'b000 && idx_ok(rd_f, NR_REGS) && idx_ok(rs1_f, NR_REGS)) begin
        illegal = 1'b0;
        wen     = 1'b1;
      end
      OP: if (f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000) &&
              idx_ok(rd_f, NR_REGS) && idx_ok(rs1_f, NR_REGS) && idx_ok(rs2_f, NR_REGS)) begin
        illegal = 1'b0;
        use_imm = 1'b0;
        alu_op  = f7[5] ? ALU_SUB : ALU_ADD;
        wen     = 1'b1;
      end
      LUI: if (idx_ok(rd_f, NR_REGS)) begin
        illegal = 1'b0;
        imm_sel = IMM_U;
        alu_op  = ALU_PASSB;
        wen     = 1'b1;
      end
      AUIPC: if (idx_ok(rd_f, NR_REGS)) begin
        illegal = 1'b0;
        imm_sel = IMM_U;
        use_pc  = 1'b1;
        wen     = 1'b1;
      end
      JAL: if (idx_ok(rd_f, NR_REGS)) begin
        illegal = 1'b0;
        imm_sel = IMM_J;
        use_pc  = 1'b1;
        is_jump = 1'b1;
        wen     = 1'b1;
      end
      JALR: if (f3 == 3'b000 && idx_ok(rd_f, NR_REGS) && idx_ok(rs1_f, NR_REGS)) begin
        illegal = 1'b0;
        is_jump = 1'b1;
        wen     = 1'b1;
      end
      SYSTEM: if (inst_q == EBREAK_INST) begin
        illegal   = 1'b0;
        is_ebreak = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm = gen_imm(inst_q, imm_sel);

  always_comb begin
    case (alu_op)
      ALU_SUB:   alu_out = op_a - op_b;
      ALU_PASSB: alu_out = op_b;
      default:   alu_out = op_a + op_b;
    endcase
  end

  npc_regfile #(.NR_REGS(NR_REGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .ra1    (rs1_f[REG_AW-1:0]),
    .rd1    (rs1_val),
    .ra2    (rs2_f[REG_AW-1:0]),
    .rd2    (rs2_val),
    .dbg_ra (dbg_raddr),
    .dbg_rd (dbg_rdata),
    .we     (rf_we),
    .wa     (rd_f[REG_AW-1:0]),
    .wd     (res_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ifetch_req = 1'b0;
    trap_set   = 1'b0;
    rf_we      = 1'b0;
    case (state)
      S_FETCH: begin
        ifetch_req = 1'b1;
        if (ifetch_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
          state_nx = S_HALT;
          trap_set = 1'b1;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_jump && alu_out[1]) begin
          state_nx = S_HALT;
          trap_set = 1'b1;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        if (is_ebreak) begin
          state_nx = S_HALT;
        end else begin
          rf_we    = wen;
          state_nx = S_FETCH;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  // Jumps route their target through the ALU (base + imm); the link value is pc+4.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
      npc_q  <= '0;
      trap_q <= 1'b0;
    end else begin
      if (state == S_FETCH && ifetch_valid) inst_q <= ifetch_inst;
      if (state == S_DECODE) begin
        op_a <= use_pc ? pc_q : rs1_val;
        op_b <= use_imm ? imm : rs2_val;
      end
      if (state == S_EXEC) begin
        res_q <= is_jump ? pc_q + 32'd4 : alu_out;
        npc_q <= is_jump ? {alu_out[31:1], 1'b0} : pc_q + 32'd4;
      end
      if (state == S_WB && !is_ebreak) pc_q <= npc_q;
      if (trap_set) trap_q <= 1'b1;
    end
  end

  assign pc          = pc_q;
  assign ifetch_addr = pc_q;
  assign halt        = (state == S_HALT);
  assign trap        = trap_q;

`ifdef NPC_MC_COMMIT_TRACE_EN
  assign commit_valid = (state == S_WB);
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
`endif

endmodule

// File: tb/tb_npc_mc.sv
// Directed testbench for npc_mc; a second RV32E instance shares the stimulus.
module tb_npc_mc;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_valid = 1'b0;
  logic [31:0] ifetch_inst = '0;
  logic [4:0]  dbg_raddr = '0;
  logic        ifetch_req, halt, trap;
  logic [31:0] ifetch_addr, pc, dbg_rdata;
  logic        ifetch_req16, halt16, trap16;
  logic [31:0] ifetch_addr16, pc16, dbg_rdata16;
`ifdef NPC_MC_COMMIT_TRACE_EN
  logic        commit_valid, commit_valid16;
  logic [31:0] commit_pc, commit_inst, commit_pc16, commit_inst16;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npc_mc #(.RESET_PC(RPC), .NR_REGS(32)) u_dut (
    .clk(clk), .rst(rst), .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ifetch_valid(ifetch_valid), .ifetch_inst(ifetch_inst), .pc(pc), .halt(halt),
    .trap(trap), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef NPC_MC_COMMIT_TRACE_EN
    , .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst)
`endif
  );

  npc_mc #(.RESET_PC(RPC), .NR_REGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .ifetch_req(ifetch_req16), .ifetch_addr(ifetch_addr16),
    .ifetch_valid(ifetch_valid), .ifetch_inst(ifetch_inst), .pc(pc16), .halt(halt16),
    .trap(trap16), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata16)
`ifdef NPC_MC_COMMIT_TRACE_EN
    , .commit_valid(commit_valid16), .commit_pc(commit_pc16), .commit_inst(commit_inst16)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifetch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a fetch request, return one instruction, then step through DECODE/EXEC/WB.
  task automatic feed(input logic [31:0] w, input int unsigned waits);
    int unsigned n = 0;
    while (!ifetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ifetch_req) begin
      failures++;
      $display("FAIL fetch_timeout inst=%h ifetch_req=%b required=1", w, ifetch_req);
    end
    for (int unsigned i = 0; i < waits; i++) @(negedge clk);
    ifetch_valid = 1'b1;
    ifetch_inst  = w;
    @(negedge clk);
    ifetch_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
    checks++; if ({halt, trap} !== 2'b00) begin failures++; $display("FAIL reset_halt_trap got=%b exp=00", {halt, trap}); end
    checks++; if (ifetch_req !== 1'b1 || ifetch_addr !== RPC) begin
      failures++; $display("FAIL reset_fetch req=%b addr=%h exp req=1 addr=%h", ifetch_req, ifetch_addr, RPC);
    end
  endtask

  task automatic test_addi();
    logic [3:0] r;
    do_reset();
    ifetch_valid = 1'b1;
    ifetch_inst  = 32'hFFD0_0193;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifetch_valid = 1'b0;
      r[i] = ifetch_req;
    end
    checks++; if (r !== 4'b1000) begin failures++; $display("FAIL addi_cycle_req got=%b exp=1000", r); end
    checks++; if (pc !== RPC + 32'd4) begin failures++; $display("FAIL addi_pc got=%h exp=%h", pc, RPC + 32'd4); end
    dbg_raddr = 5'd3; #1;
    checks++; if (dbg_rdata !== 32'hFFFF_FFFD) begin failures++; $display("FAIL addi_x3 got=%h exp=fffffffd", dbg_rdata); end
  endtask

  task automatic test_back_to_back();
    int unsigned n = 0;
    logic held = 1'b1;
    do_reset();
    feed(32'h1234_50B7, 0);
    for (int i = 0; i < 3; i++) begin
      held = held & ifetch_req;
      @(negedge clk);
      n++;
    end
    held = held & ifetch_req;
    ifetch_valid = 1'b1;
    ifetch_inst  = 32'h6780_8093;
    @(negedge clk);
    n++;
    ifetch_valid = 1'b0;
    while (!ifetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL wait_req_held got=%b exp=1", held); end
    checks++; if (n != 7) begin failures++; $display("FAIL wait_cycles got=%0d exp=7", n); end
    feed(32'h0010_8133, 0);
    feed(32'h4011_0233, 0);
    dbg_raddr = 5'd1; #1;
    checks++; if (dbg_rdata !== 32'h1234_5678) begin failures++; $display("FAIL lui_addi_x1 got=%h exp=12345678", dbg_rdata); end
    dbg_raddr = 5'd2; #1;
    checks++; if (dbg_rdata !== 32'h2468_ACF0) begin failures++; $display("FAIL add_x2 got=%h exp=2468acf0", dbg_rdata); end
    dbg_raddr = 5'd4; #1;
    checks++; if (dbg_rdata !== 32'h1234_5678) begin failures++; $display("FAIL sub_x4 got=%h exp=12345678", dbg_rdata); end
    checks++; if (pc !== RPC + 32'd16) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, RPC + 32'd16); end
  endtask

  task automatic test_jumps();
    do_reset();
    feed(32'h0080_02EF, 0);
    dbg_raddr = 5'd5; #1;
    checks++; if (dbg_rdata !== RPC + 32'd4) begin failures++; $display("FAIL jal_link got=%h exp=%h", dbg_rdata, RPC + 32'd4); end
    checks++; if (pc !== RPC + 32'd8) begin failures++; $display("FAIL jal_pc got=%h exp=%h", pc, RPC + 32'd8); end
    feed(32'h0012_8067, 0);
    checks++; if (pc !== RPC + 32'd4 || halt !== 1'b0) begin
      failures++; $display("FAIL jalr_pc got=%h halt=%b exp=%h halt=0", pc, halt, RPC + 32'd4);
    end
    feed(32'h0022_8367, 0);
    checks++; if ({halt, trap} !== 2'b11) begin failures++; $display("FAIL misalign_trap got=%b exp=11", {halt, trap}); end
    checks++; if (pc !== RPC + 32'd4) begin failures++; $display("FAIL misalign_pc got=%h exp=%h", pc, RPC + 32'd4); end
    dbg_raddr = 5'd6; #1;
    checks++; if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL misalign_no_wb got=%h exp=0", dbg_rdata); end
  endtask

  task automatic test_x0_and_wrap();
    do_reset();
    feed(32'h0050_0013, 0);
    dbg_raddr = 5'd0; #1;
    checks++; if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL x0_write got=%h exp=0", dbg_rdata); end
    feed(32'hFFC0_0393, 0);
    feed(32'h0003_8067, 0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jump_pc got=%h exp=fffffffc", pc); end
    feed(32'h0000_0013, 0);
    checks++; if (pc !== 32'h0 || halt !== 1'b0) begin failures++; $display("FAIL wrap_pc got=%h halt=%b exp=0 halt=0", pc, halt); end
  endtask

  task automatic test_ebreak();
    logic seen_req = 1'b0;
    do_reset();
    ifetch_valid = 1'b1;
    ifetch_inst  = 32'h0010_0073;
    @(negedge clk);
    ifetch_valid = 1'b0;
    repeat (2) @(negedge clk);
`ifdef NPC_MC_COMMIT_TRACE_EN
    checks++; if (commit_valid !== 1'b1 || commit_pc !== RPC || commit_inst !== 32'h0010_0073) begin
      failures++; $display("FAIL commit_ebreak v=%b pc=%h inst=%h exp v=1 pc=%h inst=00100073", commit_valid, commit_pc, commit_inst, RPC);
    end
`endif
    @(negedge clk);
    checks++; if ({halt, trap} !== 2'b10) begin failures++; $display("FAIL ebreak_halt got=%b exp=10", {halt, trap}); end
    checks++; if (pc !== RPC) begin failures++; $display("FAIL ebreak_pc got=%h exp=%h", pc, RPC); end
    for (int i = 0; i < 20; i++) begin
      ifetch_valid = i[0];
      seen_req = seen_req | ifetch_req;
`ifdef NPC_MC_COMMIT_TRACE_EN
      seen_req = seen_req | commit_valid;
`endif
      @(negedge clk);
    end
    ifetch_valid = 1'b0;
    checks++; if (seen_req !== 1'b0 || halt !== 1'b1) begin
      failures++; $display("FAIL halt_absorbing req_seen=%b halt=%b exp req_seen=0 halt=1", seen_req, halt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    feed(32'h0000_0000, 0);
    checks++; if ({halt, trap} !== 2'b11 || pc !== RPC) begin
      failures++; $display("FAIL illegal_zero halt_trap=%b pc=%h exp 11 pc=%h", {halt, trap}, pc, RPC);
    end
  endtask

  task automatic test_rv32e();
    do_reset();
    feed(32'h0070_0793, 0);
    dbg_raddr = 5'd15; #1;
    checks++; if (dbg_rdata16 !== 32'd7) begin failures++; $display("FAIL rv32e_x15 got=%h exp=7", dbg_rdata16); end
    feed(32'h0010_0A13, 0);
    checks++; if ({halt16, trap16} !== 2'b11 || pc16 !== RPC + 32'd4) begin
      failures++; $display("FAIL rv32e_x20_trap halt_trap=%b pc=%h exp 11 pc=%h", {halt16, trap16}, pc16, RPC + 32'd4);
    end
    checks++; if (halt !== 1'b0 || pc !== RPC + 32'd8) begin
      failures++; $display("FAIL rv32i_x20_ok halt=%b pc=%h exp halt=0 pc=%h", halt, pc, RPC + 32'd8);
    end
    dbg_raddr = 5'd20; #1;
    checks++; if (dbg_rdata !== 32'd1 || dbg_rdata16 !== 32'd0) begin
      failures++; $display("FAIL dbg_x20 rv32i=%h rv32e=%h exp 1 and 0", dbg_rdata, dbg_rdata16);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    feed(32'hFFD0_0193, 0);
    @(negedge clk);
    rst = 1'b1;
    ifetch_valid = 1'b1;
    ifetch_inst  = 32'h0010_0493;
    @(negedge clk);
    rst = 1'b0;
    ifetch_valid = 1'b0;
    checks++; if (pc !== RPC || ifetch_req !== 1'b1 || ifetch_addr !== RPC) begin
      failures++; $display("FAIL midfetch_reset pc=%h req=%b addr=%h exp pc=%h req=1", pc, ifetch_req, ifetch_addr, RPC);
    end
    dbg_raddr = 5'd3; #1;
    checks++; if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL midfetch_clear_x3 got=%h exp=0", dbg_rdata); end
    @(negedge clk);
    dbg_raddr = 5'd9; #1;
    checks++; if (ifetch_req !== 1'b1 || dbg_rdata !== 32'd0) begin
      failures++; $display("FAIL midfetch_ignored req=%b x9=%h exp req=1 x9=0", ifetch_req, dbg_rdata);
    end
    feed(32'h0010_0493, 0);
    checks++; if (dbg_rdata !== 32'd1 || pc !== RPC + 32'd4) begin
      failures++; $display("FAIL midfetch_refetch x9=%h pc=%h exp x9=1 pc=%h", dbg_rdata, pc, RPC + 32'd4);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jumps();
    test_x0_and_wrap();
    test_ebreak();
    test_illegal();
    test_rv32e();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_mc.md
Name: npc_mc

Overview:
Multi-cycle RV32I-subset core top, successor to the single-cycle npc (pc_4 + decoder + alu).
- Adds an instruction-fetch handshake, an explicit FSM, a synchronous reset, a parametrised register file, and halt/trap on EBREAK or illegal encodings.
- Sits between the C-side memory model and the difftest/trace harness.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NR_REGS, 32, GPR count: 32 = RV32I, 16 = RV32E. Any rs1/rs2/rd index >= NR_REGS traps as illegal.
- REG_AW, $clog2(NR_REGS), derived index width. Do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ifetch_req  out  1  fetch request; high only in FETCH.
- ifetch_addr  out  32  fetch address (= pc).
- ifetch_valid  in  1  instruction-return strobe; sampled only while ifetch_req=1.
- ifetch_inst  in  32  instruction word, valid with ifetch_valid.
- pc  out  32  architectural PC.
- halt  out  1  core stopped (sticky).
- trap  out  1  halt cause: 0 = EBREAK, 1 = illegal/misaligned (sticky).
- dbg_raddr  in  5  debug GPR read index.
- dbg_rdata  out  32  combinational GPR read. Returns 0 for index 0 or >= NR_REGS.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - pc=RESET_PC, state=FETCH, all GPRs=0, inst register=0, halt=0, trap=0.
  - Reset overrides every state, including mid-fetch. A pending fetch is abandoned.
  - ifetch_valid arriving in or after the reset cycle, before the new FETCH asserts ifetch_req, is ignored.
- FSM states: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT.
  - FETCH: ifetch_req=1, ifetch_addr=pc. Stays in FETCH while ifetch_valid=0 (unbounded wait states). On ifetch_valid=1, latch ifetch_inst and go to DECODE.
  - DECODE: read rs1/rs2, generate imm (I/S/U/J formats, sign-extended), classify op. Illegal -> HALT, trap=1.
  - EXEC: compute result and next_pc.
  - WB: write rd unless rd=0, pc<=next_pc, go to FETCH. EBREAK goes to HALT instead (trap=0, pc unchanged).
  - HALT: absorbing. ifetch_req=0, no GPR or pc writes. Exit only via rst.
- Throughput: 4 cycles per instruction with zero-wait memory, plus 1 cycle per fetch wait state.
- Supported operations:
  - ADDI, ADD, SUB: 32-bit wrap-around, no overflow flag.
  - LUI: rd = imm[31:12]<<12.
  - AUIPC: rd = pc + U-imm.
  - JAL: rd = pc+4, pc += J-imm.
  - JALR: rd = pc+4, pc = (rs1+I-imm) & ~1. Read rs1 before the write, so rd==rs1 uses the old value.
  - EBREAK (32'h0010_0073).
  - Everything else, including opcode bits[1:0] != 2'b11, is illegal.
- Misaligned branch target: next_pc[1] = 1 on JAL/JALR -> HALT, trap=1. No rd write and pc unchanged.
- x0: reads are always 0; writes are discarded.
- pc increments by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).

Optional Feature:
- Macro: NPC_MC_COMMIT_TRACE_EN.
- Defined: adds outputs commit_valid (1), commit_pc (32), commit_inst (32).
  - commit_valid pulses high for exactly one cycle in WB of each retired instruction, including EBREAK.
  - commit_pc and commit_inst carry that instruction's values.
  - Never asserted in HALT or for trapped illegal/misaligned instructions.
- Undefined: ports absent, no trace logic; all other behaviour identical.

Decomposition:
- Package npc_pkg holds:
  - opcode constants (OP_IMM, OP, LUI, AUIPC, JAL, JALR, SYSTEM), EBREAK_INST;
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT);
  - imm-type enum (IMM_I, IMM_S, IMM_U, IMM_J);
  - alu-op enum (ALU_ADD, ALU_SUB, ALU_PASSB).
- One sub-module: npc_regfile.
  - Parameter NR_REGS.
  - Two combinational read ports plus the debug read port.
  - One synchronous write port with x0 suppression; synchronous clear on rst.

Test Plan:
- Reset, then zero-wait fetch returning 32'hFFD00193 (addi x3,x0,-3) -> after 4 cycles x3=32'hFFFF_FFFD, pc=RESET_PC+4.
- lui x1,0x12345; addi x1,x1,0x678; add x2,x1,x1 -> x1=32'h1234_5678, x2=32'h2468_ACF0. Inject 3 wait states on the second fetch -> ifetch_req held, exactly 3 extra cycles.
- jal x5,+8 at RESET_PC -> x5=RESET_PC+4, pc=RESET_PC+8. jalr x0,x5,1 -> pc=RESET_PC+4 (bit0 cleared). jalr with target bit1=1 -> halt=1, trap=1, pc unchanged.
- addi x0,x0,5 -> dbg_rdata(0)=0. NR_REGS=16 build: addi x20,x0,1 -> halt=1, trap=1.
- ebreak (32'h0010_0073) -> halt=1, trap=0, ifetch_req stays 0 for 20 cycles. 32'h0000_0000 -> trap=1.
- rst asserted while FETCH waits, with ifetch_valid pulsed in the same cycle -> pc=RESET_PC, no GPR write, fresh fetch from RESET_PC next cycle.
